// File: rtl/axi_pkg.sv
// Shared definitions for the AXI read-side scheduler: requester IDs,
// scheduler state encoding and AXI transfer size codes.
package axi_pkg;

  localparam logic [3:0] ID_INST = 4'd0;
  localparam logic [3:0] ID_DATA = 4'd1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } rd_state_e;

  localparam logic [2:0] AXI_SIZE_1B = 3'd0;
  localparam logic [2:0] AXI_SIZE_2B = 3'd1;
  localparam logic [2:0] AXI_SIZE_4B = 3'd2;

endpackage

// File: rtl/rd_outst_cnt.sv
// Up/down counter of in-flight reads for one AXI ID. Increments on an
// accepted AR, decrements on the last R beat, saturates at both ends and
// flags an attempt to decrement below zero.
module rd_outst_cnt #(
  parameter int MAX_CNT = 2,
  parameter int CW      = $clog2(MAX_CNT + 1)
) (
  input  logic          aclk,
  input  logic          aresetn,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] count,
  output logic          underflow
);

  // A lone decrement at zero is a response nobody asked for.
  assign underflow = dec & ~inc & (count == '0);

  // Track in-flight reads; simultaneous inc and dec cancel out.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      count <= '0;
    end else if (inc && !dec && (count != CW'(MAX_CNT))) begin
      count <= count + CW'(1);
    end else if (dec && !inc && (count != '0)) begin
      count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/axi_rd_sched.sv
// Read-request scheduler: arbitrates instruction (m0) and data (m1) read
// requests onto one AXI AR channel, tags them with the requester ID, counts
// outstanding reads per ID, routes R beats back by rid and holds off reads
// that hit the word of a pending write.
module axi_rd_sched
  import axi_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2,
  parameter int STARVE_LIMIT    = 4
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        m0_arvalid,
  input  logic [31:0] m0_araddr,
  input  logic [2:0]  m0_arsize,
  output logic        m0_arready,
  input  logic        m1_arvalid,
  input  logic [31:0] m1_araddr,
  input  logic [2:0]  m1_arsize,
  output logic        m1_arready,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  input  logic        m0_rready,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  input  logic        m1_rready,
  input  logic        wr_pend,
  input  logic [31:0] wr_pend_addr,
  output logic        err_rid
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  rd_state_e     state;
  rd_state_e     state_next;
  logic [CW-1:0] cnt0;
  logic [CW-1:0] cnt1;
  logic [SW-1:0] starve;
  logic          hazard0;
  logic          hazard1;
  logic          elig0;
  logic          elig1;
  logic          force0;
  logic          grant0;
  logic          grant1;
  logic          ar_hs;
  logic          r_done;
  logic          rid_bad;
  logic          uf0;
  logic          uf1;
  logic          unused_bits;

  // rresp is not interpreted and the byte-offset bits of the write address
  // do not take part in the word-level hazard compare.
  assign unused_bits = ^{rresp, wr_pend_addr[1:0]};

  assign hazard0 = wr_pend & (m0_araddr[31:2] == wr_pend_addr[31:2]);
  assign hazard1 = wr_pend & (m1_araddr[31:2] == wr_pend_addr[31:2]);
  assign elig0   = m0_arvalid & (cnt0 < CW'(MAX_OUTSTANDING)) & ~hazard0;
  assign elig1   = m1_arvalid & (cnt1 < CW'(MAX_OUTSTANDING)) & ~hazard1;

  // Data port has fixed priority unless instruction fetch has starved.
  assign force0 = (starve == SW'(STARVE_LIMIT)) & elig0;
  assign grant1 = (state == IDLE) & elig1 & ~force0;
  assign grant0 = (state == IDLE) & elig0 & (force0 | ~elig1);

  assign ar_hs  = arvalid & arready;
  assign r_done = rvalid & rready & rlast;

  // Scheduler state register.
  always_ff @(posedge aclk) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_next;
  end

  // Grant moves to BUSY; the AR handshake returns to IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant0 || grant1) state_next = BUSY;
      BUSY:    if (arready)          state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // AR-side outputs derived from state and the current grant.
  always_comb begin
    arvalid    = (state == BUSY);
    m0_arready = grant0;
    m1_arready = grant1;
  end

  // Capture the granted request; held stable while waiting for arready.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      arid   <= '0;
      araddr <= '0;
      arsize <= '0;
    end else if (grant1) begin
      arid   <= ID_DATA;
      araddr <= m1_araddr;
      arsize <= m1_arsize;
    end else if (grant0) begin
      arid   <= ID_INST;
      araddr <= m0_araddr;
      arsize <= m0_arsize;
    end
  end

  // Count how many times in a row fetch lost while it could have gone.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      starve <= '0;
    end else if (grant0) begin
      starve <= '0;
    end else if (grant1 && elig0 && (starve != SW'(STARVE_LIMIT))) begin
      starve <= starve + SW'(1);
    end
  end

  // Steer R beats by rid; unknown IDs are swallowed and flagged.
  always_comb begin
    m0_rvalid = 1'b0;
    m1_rvalid = 1'b0;
    rready    = 1'b1;
    rid_bad   = 1'b0;
    case (rid)
      ID_INST: begin
        m0_rvalid = rvalid;
        rready    = m0_rready;
      end
      ID_DATA: begin
        m1_rvalid = rvalid;
        rready    = m1_rready;
      end
      default: rid_bad = rvalid;
    endcase
  end

  assign m0_rdata = rdata;
  assign m1_rdata = rdata;

  rd_outst_cnt #(.MAX_CNT(MAX_OUTSTANDING), .CW(CW)) u_cnt_inst (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .inc       (ar_hs & (arid == ID_INST)),
    .dec       (r_done & (rid == ID_INST)),
    .count     (cnt0),
    .underflow (uf0)
  );

  rd_outst_cnt #(.MAX_CNT(MAX_OUTSTANDING), .CW(CW)) u_cnt_data (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .inc       (ar_hs & (arid == ID_DATA)),
    .dec       (r_done & (rid == ID_DATA)),
    .count     (cnt1),
    .underflow (uf1)
  );

  // Sticky error: unknown rid or a response with nothing outstanding.
  always_ff @(posedge aclk) begin
    if (!aresetn)                  err_rid <= 1'b0;
    else if (rid_bad | uf0 | uf1)  err_rid <= 1'b1;
  end

endmodule

// File: tb/tb_axi_rd_sched.sv
// Bench for axi_rd_sched: directed scenarios with literal expectations plus
// a transaction-level model compared against the DUT every cycle.
module tb_axi_rd_sched;

  localparam int MAXO = 2;
  localparam int SLIM = 4;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        m0_arvalid, m1_arvalid, m0_arready, m1_arready;
  logic [31:0] m0_araddr, m1_araddr;
  logic [2:0]  m0_arsize, m1_arsize;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;
  logic        m0_rvalid, m1_rvalid, m0_rready, m1_rready;
  logic [31:0] m0_rdata, m1_rdata;
  logic        wr_pend;
  logic [31:0] wr_pend_addr;
  logic        err_rid;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state
  bit          model_ok = 0;
  bit          m_busy;
  int          m_arid;
  logic [31:0] m_araddr;
  logic [2:0]  m_arsize;
  int          m_out[2];
  int          m_starve;
  bit          m_err;

  // Responder and grant log
  bit         resp_en = 0;
  logic [3:0] rq[$];
  int         glog[$];

  axi_rd_sched #(.MAX_OUTSTANDING(MAXO), .STARVE_LIMIT(SLIM)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .m0_arvalid(m0_arvalid), .m0_araddr(m0_araddr), .m0_arsize(m0_arsize), .m0_arready(m0_arready),
    .m1_arvalid(m1_arvalid), .m1_araddr(m1_araddr), .m1_arsize(m1_arsize), .m1_arready(m1_arready),
    .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_rready(m0_rready),
    .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_rready(m1_rready),
    .wr_pend(wr_pend), .wr_pend_addr(wr_pend_addr), .err_rid(err_rid)
  );

  always #5 aclk = ~aclk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: compare outputs mid-cycle, then advance by the rules of one edge.
  always begin
    bit h0, h1, e0, e1, exp_v0, exp_v1, exp_rr;
    int win;
    int inc[2];
    int dec[2];
    @(negedge aclk);
    #3;
    h0 = wr_pend && (m0_araddr[31:2] == wr_pend_addr[31:2]);
    h1 = wr_pend && (m1_araddr[31:2] == wr_pend_addr[31:2]);
    e0 = m0_arvalid && (m_out[0] < MAXO) && !h0;
    e1 = m1_arvalid && (m_out[1] < MAXO) && !h1;
    win = -1;
    if (!m_busy) begin
      if (m_starve == SLIM && e0) win = 0;
      else if (e1)                win = 1;
      else if (e0)                win = 0;
    end
    exp_v0 = 0; exp_v1 = 0; exp_rr = 1;
    if (rid == 4'd0)      begin exp_v0 = rvalid; exp_rr = m0_rready; end
    else if (rid == 4'd1) begin exp_v1 = rvalid; exp_rr = m1_rready; end
    if (model_ok) begin
      checkOutput("m0_arready", m0_arready, (win == 0));
      checkOutput("m1_arready", m1_arready, (win == 1));
      checkOutput("arvalid", arvalid, m_busy);
      checkOutput("arid", arid, m_arid);
      checkOutput("araddr", araddr, m_araddr);
      checkOutput("arsize", arsize, m_arsize);
      checkOutput("rready", rready, exp_rr);
      checkOutput("m0_rvalid", m0_rvalid, exp_v0);
      checkOutput("m1_rvalid", m1_rvalid, exp_v1);
      checkOutput("m0_rdata", m0_rdata, rdata);
      checkOutput("m1_rdata", m1_rdata, rdata);
      checkOutput("err_rid", err_rid, m_err);
    end
    if (!aresetn) begin
      m_busy = 0; m_arid = 0; m_araddr = '0; m_arsize = '0;
      m_out[0] = 0; m_out[1] = 0; m_starve = 0; m_err = 0;
      model_ok = 1;
    end else begin
      inc[0] = 0; inc[1] = 0; dec[0] = 0; dec[1] = 0;
      if (m_busy && arready) begin
        m_busy = 0;
        if (m_arid < 2) inc[m_arid] = 1;
      end
      if (win >= 0) begin
        m_busy   = 1;
        m_arid   = win;
        m_araddr = (win == 1) ? m1_araddr : m0_araddr;
        m_arsize = (win == 1) ? m1_arsize : m0_arsize;
        if (win == 0) m_starve = 0;
        else if (e0 && m_starve < SLIM) m_starve++;
      end
      if (rvalid) begin
        if (rid > 4'd1) m_err = 1;
        else if (exp_rr && rlast) dec[int'(rid)] = 1;
      end
      for (int i = 0; i < 2; i++) begin
        if (inc[i] == 1 && dec[i] == 0) m_out[i]++;
        else if (dec[i] == 1 && inc[i] == 0) begin
          if (m_out[i] == 0) m_err = 1;
          else m_out[i]--;
        end
      end
    end
  end

  // Bookkeeping for the auto-responder and the grant sequence.
  always begin
    @(negedge aclk);
    #3;
    if (aresetn) begin
      if (m0_arready) glog.push_back(0);
      if (m1_arready) glog.push_back(1);
      if (resp_en) begin
        if (rvalid && rready && rlast && rq.size() > 0) void'(rq.pop_front());
        if (arvalid && arready) rq.push_back(arid);
      end
    end
  end

  task automatic applyStimulus(input logic v0, input logic [31:0] a0,
                               input logic v1, input logic [31:0] a1,
                               input logic ar_rdy);
    @(negedge aclk);
    m0_arvalid = v0; m0_araddr = a0; m0_arsize = 3'd2;
    m1_arvalid = v1; m1_araddr = a1; m1_arsize = 3'd1;
    arready = ar_rdy;
    rvalid = 1'b0; rlast = 1'b0; rid = 4'd0; rdata = 32'h0;
  endtask

  task automatic resetDut(input int n);
    @(negedge aclk);
    aresetn = 1'b0;
    m0_arvalid = 0; m1_arvalid = 0; arready = 0; rvalid = 0; rlast = 0;
    wr_pend = 0;
    repeat (n) @(negedge aclk);
    aresetn = 1'b1;
    #4;
  endtask

  initial begin
    int exp_g[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    aresetn = 1'b0;
    m0_arvalid = 0; m0_araddr = 0; m0_arsize = 0;
    m1_arvalid = 0; m1_araddr = 0; m1_arsize = 0;
    arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;
    m0_rready = 1; m1_rready = 1; wr_pend = 0; wr_pend_addr = 0;

    // Reset values
    resetDut(2);
    checkOutput("rst_arvalid", arvalid, 0);
    checkOutput("rst_arid", arid, 0);
    checkOutput("rst_araddr", araddr, 0);
    checkOutput("rst_err_rid", err_rid, 0);

    // Single fetch request and its response
    applyStimulus(1, 32'h1C000000, 0, 0, 0); #4;
    checkOutput("s1_grant", m0_arready, 1);
    applyStimulus(0, 32'h1C000000, 0, 0, 0); #4;
    checkOutput("s1_arvalid", arvalid, 1);
    checkOutput("s1_arid", arid, 0);
    checkOutput("s1_araddr", araddr, 32'h1C000000);
    checkOutput("s1_arsize", arsize, 2);
    applyStimulus(0, 0, 0, 0, 1); #4;
    checkOutput("s1_hold", arvalid, 1);
    applyStimulus(0, 0, 0, 0, 0);
    rvalid = 1; rid = 0; rdata = 32'hDEADBEEF; rlast = 1; #4;
    checkOutput("s1_arvalid_drop", arvalid, 0);
    checkOutput("s1_m0_rvalid", m0_rvalid, 1);
    checkOutput("s1_m0_rdata", m0_rdata, 32'hDEADBEEF);
    checkOutput("s1_m1_rvalid", m1_rvalid, 0);

    // Starvation: data wins four times, then fetch is forced through
    resetDut(1);
    glog.delete();
    rq.delete();
    resp_en = 1;
    for (int c = 0; c < 40; c++) begin
      applyStimulus(1, 32'h3000, 1, 32'h4000, 1);
      if (rq.size() > 0) begin
        rvalid = 1; rid = rq[0]; rlast = 1; rdata = 32'hA5A50000 + c;
      end
    end
    for (int c = 0; c < 6; c++) begin
      applyStimulus(0, 0, 0, 0, 1);
      if (rq.size() > 0) begin
        rvalid = 1; rid = rq[0]; rlast = 1; rdata = 32'h5A5A0000 + c;
      end
    end
    resp_en = 0;
    checkOutput("s2_grants", (glog.size() >= 10), 1);
    if (glog.size() >= 10)
      for (int i = 0; i < 10; i++) checkOutput($sformatf("s2_grant%0d", i), glog[i], exp_g[i]);

    // Read-after-write hazard
    resetDut(1);
    wr_pend = 1; wr_pend_addr = 32'h00001004;
    applyStimulus(1, 32'h2000, 1, 32'h1006, 1); #4;
    checkOutput("s3_m1_blocked", m1_arready, 0);
    checkOutput("s3_m0_grant", m0_arready, 1);
    applyStimulus(0, 32'h2000, 1, 32'h1006, 1); #4;
    checkOutput("s3_ar_m0", araddr, 32'h2000);
    applyStimulus(0, 32'h2000, 1, 32'h1006, 1); #4;
    checkOutput("s3_still_blocked", m1_arready, 0);
    checkOutput("s3_no_ar", arvalid, 0);
    applyStimulus(0, 32'h2000, 1, 32'h1006, 1);
    wr_pend = 0; #4;
    checkOutput("s3_m1_grant", m1_arready, 1);
    applyStimulus(0, 0, 0, 32'h1006, 1); #4;
    checkOutput("s3_arid", arid, 1);
    checkOutput("s3_araddr", araddr, 32'h1006);

    // Outstanding limit on the data ID
    resetDut(1);
    applyStimulus(0, 0, 1, 32'h5000, 1); #4;
    checkOutput("s4_g1", m1_arready, 1);
    applyStimulus(0, 0, 1, 32'h5000, 1);
    applyStimulus(0, 0, 1, 32'h5000, 1); #4;
    checkOutput("s4_g2", m1_arready, 1);
    applyStimulus(0, 0, 1, 32'h5000, 1);
    applyStimulus(0, 0, 1, 32'h5000, 1); #4;
    checkOutput("s4_held", m1_arready, 0);
    applyStimulus(0, 0, 1, 32'h5000, 1);
    rvalid = 1; rid = 1; rlast = 1; rdata = 32'h12345678; #4;
    checkOutput("s4_m1_rvalid", m1_rvalid, 1);
    checkOutput("s4_held_r", m1_arready, 0);
    applyStimulus(0, 0, 1, 32'h5000, 1); #4;
    checkOutput("s4_g3", m1_arready, 1);
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0);

    // Unknown rid, sticky error, reset clears it and the counters
    applyStimulus(0, 0, 0, 0, 0);
    m0_rready = 0; m1_rready = 0;
    rvalid = 1; rid = 3; rlast = 1; rdata = 32'hBAD0BAD0; #4;
    checkOutput("s5_rready", rready, 1);
    checkOutput("s5_m0_rvalid", m0_rvalid, 0);
    checkOutput("s5_m1_rvalid", m1_rvalid, 0);
    applyStimulus(0, 0, 0, 0, 0); #4;
    checkOutput("s5_err", err_rid, 1);
    applyStimulus(0, 0, 0, 0, 0); #4;
    checkOutput("s5_err_sticky", err_rid, 1);
    m0_rready = 1; m1_rready = 1;
    resetDut(1);
    checkOutput("s5_err_clr", err_rid, 0);
    checkOutput("s5_arvalid", arvalid, 0);
    applyStimulus(0, 0, 1, 32'h6000, 1); #4;
    checkOutput("s5_g1", m1_arready, 1);
    applyStimulus(0, 0, 1, 32'h6000, 1);
    applyStimulus(0, 0, 1, 32'h6000, 1); #4;
    checkOutput("s5_g2", m1_arready, 1);
    applyStimulus(0, 0, 0, 0, 1);

    // Reset while an AR is waiting for arready
    applyStimulus(1, 32'h7000, 0, 0, 0); #4;
    checkOutput("s6_grant", m0_arready, 1);
    applyStimulus(0, 32'h7000, 0, 0, 0); #4;
    checkOutput("s6_busy", arvalid, 1);
    @(negedge aclk);
    aresetn = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1; #4;
    checkOutput("s6_arvalid_rst", arvalid, 0);
    applyStimulus(0, 0, 1, 32'h8000, 0); #4;
    checkOutput("s6_fresh_grant", m1_arready, 1);
    applyStimulus(0, 0, 0, 0, 1); #4;
    checkOutput("s6_araddr", araddr, 32'h8000);

    // Response for an ID with nothing outstanding
    applyStimulus(0, 0, 0, 0, 0);
    rvalid = 1; rid = 0; rlast = 1; rdata = 32'h0BADF00D; #4;
    checkOutput("s7_err_pre", err_rid, 0);
    applyStimulus(0, 0, 0, 0, 0); #4;
    checkOutput("s7_err", err_rid, 1);

    repeat (3) applyStimulus(0, 0, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/axi_rd_sched.md
Name: axi_rd_sched

Overview:
- Read-request scheduler between the instruction-fetch and data-load requesters and the single AXI AR/R channel pair of the CPU bus interface.
- Arbitrates AR requests and tags each with its AXI ID.
- Tracks outstanding reads per ID and routes R beats back to the owning requester.
- Holds off any read whose word address matches a pending write, preventing stale read-after-write data.

Parameters:
- MAX_OUTSTANDING, 2, maximum in-flight reads per ID (1..3).
- STARVE_LIMIT, 4, consecutive lost arbitrations by the instruction port before it is forced to win.

Ports:
- aclk  in  1  clock
- aresetn  in  1  synchronous active-low reset
- m0_arvalid  in  1  instruction read request
- m0_araddr  in  32  instruction read address
- m0_arsize  in  3  instruction read size
- m0_arready  out  1  instruction request accepted
- m1_arvalid, m1_araddr, m1_arsize, m1_arready  same widths and directions  data read request port
- arid  out  4  AXI read ID; 0 = instruction, 1 = data
- araddr  out  32  AXI read address
- arsize  out  3  AXI read size
- arvalid  out  1  AXI AR valid
- arready  in  1  AXI AR ready
- rid  in  4  AXI R ID
- rdata  in  32  AXI R data
- rresp  in  2  AXI R response
- rlast  in  1  AXI R last beat
- rvalid  in  1  AXI R valid
- rready  out  1  AXI R ready
- m0_rvalid  out  1  instruction response valid
- m0_rdata  out  32  instruction response data
- m0_rready  in  1  instruction response ready
- m1_rvalid, m1_rdata, m1_rready  same  data response port
- wr_pend  in  1  a write is issued but its B response has not returned
- wr_pend_addr  in  32  address of the pending write
- err_rid  out  1  sticky flag: unexpected rid seen

Behaviour:
- Reset (aresetn=0 at a clock edge):
  - state←IDLE; arvalid, arid, araddr, arsize←0.
  - Both outstanding counters and the starve counter←0; err_rid←0.
  - Reset mid-transaction drops all in-flight tracking; any R beats after reset are treated as unexpected.
- State IDLE:
  - Eligibility: eligible_i = mi_arvalid & (outstanding_i < MAX_OUTSTANDING) & ~hazard_i.
  - Hazard: hazard_i = wr_pend & (mi_araddr[31:2] == wr_pend_addr[31:2]).
  - Grant: m1 wins by fixed priority, except when starve == STARVE_LIMIT, in which case m0 wins if eligible.
  - Accept: the granted mi_arready=1 combinationally in the grant cycle. The payload is registered with arid=i, and state→BUSY.
  - mi_arready is 0 whenever not granted.
- State BUSY:
  - arvalid=1; arid, araddr and arsize are held stable.
  - On arvalid&arready→IDLE.
  - No grant is made in BUSY, so there is a one-cycle bubble between consecutive ARs.
  - Latency: requester handshake in cycle N gives arvalid from N+1 at the earliest.
- Starve counter:
  - In IDLE, +1 when m0 is eligible but m1 is granted, saturating at STARVE_LIMIT.
  - Cleared when m0 is granted.
  - Held otherwise.
- Outstanding counters:
  - outstanding_i increments on AR handshake with arid=i.
  - outstanding_i decrements on rvalid&rready&rlast with rid=i.
  - Both in the same cycle for the same ID: value unchanged.
  - Width is ceil(log2(MAX_OUTSTANDING+1)); the counter never wraps because eligibility gating prevents overflow.
- R routing (all combinational):
  - rid=0: m0_rvalid=rvalid, rready=m0_rready.
  - rid=1: m1_rvalid=rvalid, rready=m1_rready.
  - mi_rdata=rdata for both ports.
  - Any other rid: rready=1 (beat dropped), both mi_rvalid=0, err_rid←1 (sticky until reset).
  - A decrement while a counter is already 0 also sets err_rid, and the counter stays at 0.
- Hazard is evaluated only at grant. An already-registered AR is not withdrawn.
- rresp is not interpreted; it is not forwarded to the requesters.

Decomposition:
- Shared package axi_pkg holds:
  - constants ID_INST=4'd0 and ID_DATA=4'd1;
  - the state encoding for IDLE and BUSY;
  - the AXI size constants.
- One sub-module, rd_outst_cnt: parameterised up/down saturating counter with an underflow flag, instantiated once per ID.

Test Plan:
- Only m0 requests addr 0x1C000000 size 2 → m0_arready=1 in cycle N; from N+1 arvalid=1, arid=0, araddr=0x1C000000 until arready; then rid=0 rdata=0xDEADBEEF rlast → m0_rvalid=1, m0_rdata=0xDEADBEEF.
- m0 and m1 both request continuously, arready=1, R returned promptly → m1 granted 4 times in a row, 5th grant goes to m0, starve counter cleared.
- wr_pend=1 with wr_pend_addr=0x00001004; m1 requests 0x00001006 → m1_arready=0 and no AR issued; m0 at 0x2000 is granted; drop wr_pend → m1 is granted the next IDLE cycle.
- m1 issues 2 ARs, no R returned, m1 still requesting → third request is held (m1_arready=0); one rlast with rid=1 → third AR granted.
- R beat with rid=3 → rready=1, m0_rvalid=m1_rvalid=0, err_rid=1 and stays set; aresetn=0 for one cycle → err_rid=0, arvalid=0, counters 0.
- Reset asserted while in BUSY with arvalid=1 → arvalid=0 the next cycle and a fresh request is granted normally after release.
